// File: rtl/uart_tx_arb_pkg.sv
// ============================================================================
// Module : uart_tx_arb_pkg
// Brief  : State encoding, header tag and ID-width helper for uart_tx_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Width of an index into N requesters, never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; first set request after i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_grant,
    output logic             o_any_req
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        for (int j = N_REQ; j >= 1; j--) begin
            if (i_req[(int'(i_ptr) + j) % N_REQ]) begin
                o_grant   = ID_W'((int'(i_ptr) + j) % N_REQ);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin, message-atomic sharing of the UART TX port.
//          Optional ID header byte enabled by UART_TX_ARB_ID_HDR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int D_BITS       = 8,
    parameter int IDLE_TIMEOUT = 1024,
    localparam int ID_W        = id_width(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*D_BITS-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [D_BITS-1:0]         w_data,
    output logic                      wr_uart,
    input  logic                      tx_full,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);

    localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  C_PTR_INIT  = ID_W'(N_REQ - 1);

    arb_state_t         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gid;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout_err;

    logic [ID_W-1:0]    w_pick;
    logic               w_any_req;
    logic               w_gnt_valid;
    logic               w_gnt_last;
    logic [D_BITS-1:0]  w_gnt_data;
    logic               w_xfer;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick),
        .o_any_req (w_any_req)
    );

    assign w_gnt_valid = req_valid[r_gid];
    assign w_gnt_last  = req_last[r_gid];
    assign w_gnt_data  = req_data[int'(r_gid)*D_BITS +: D_BITS];
    assign w_xfer      = (r_state == ST_DATA) && w_gnt_valid && !tx_full;

    // Handshake and write strobe are combinational so a byte moves in the cycle it is offered.
    always_comb begin
        req_ready = '0;
        wr_uart   = 1'b0;
        w_data    = '0;
        if (r_state == ST_DATA) begin
            req_ready[r_gid] = !tx_full;
        end
        if (w_xfer) begin
            wr_uart = 1'b1;
            w_data  = w_gnt_data;
        end
`ifdef UART_TX_ARB_ID_HDR_EN
        if ((r_state == ST_HDR) && !tx_full) begin
            wr_uart = 1'b1;
            w_data  = D_BITS'({HDR_TAG, 4'h0}) | D_BITS'(r_gid);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= C_PTR_INIT;
            r_gid         <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_any_req) begin
                        r_gid <= w_pick;
                        r_ptr <= w_pick;
`ifdef UART_TX_ARB_ID_HDR_EN
                        r_state <= ST_HDR;
`else
                        r_state <= ST_DATA;
`endif
                    end
                end
                ST_HDR: begin
                    if (!tx_full) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer && w_gnt_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (!w_gnt_valid) begin
                        // Only an absent requester ages the grant; tx_full stalls do not.
                        if (r_cnt == C_CNT_LIMIT) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= ST_IDLE;
                            r_cnt         <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign grant_id    = r_gid;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Directed and randomized bench for uart_tx_arbiter against a
//          message-level reference model (honours UART_TX_ARB_ID_HDR_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 16;
`ifdef UART_TX_ARB_ID_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DB-1:0]   w_data;
    logic            wr_uart;
    logic            tx_full;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_err;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .D_BITS       (DB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .w_data      (w_data),
        .wr_uart     (wr_uart),
        .tx_full     (tx_full),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side message queues and per-cycle offer enables.
    logic [7:0] q_dat [N][$];
    bit         q_lst [N][$];
    logic [N-1:0] en;
    int stall [N];

    // Reference model: who owns the port, whose turn is next, idle age.
    int m_owner;
    int m_ptr;
    int m_gid;
    int m_idle;
    bit m_terr;
    bit m_hdr;

    // Observation logs for the directed scenarios.
    logic [7:0] wlog[$];
    int wr_cyc[$];
    int to_cyc[$];
    int cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_gid   = 0;
        m_idle  = 0;
        m_terr  = 1'b0;
        m_hdr   = 1'b0;
    endtask

    task automatic clear_logs();
        wlog.delete();
        wr_cyc.delete();
        to_cyc.delete();
        cyc = 0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            q_dat[i].delete();
            q_lst[i].delete();
            stall[i] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        q_dat[r].push_back(d);
        q_lst[r].push_back(l);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && q_dat[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DB +: DB]  = q_dat[i][0];
                req_last[i]           = q_lst[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DB +: DB]  = 8'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
    endtask

    // One clock: drive at the falling edge, check mid-low phase, advance model.
    task automatic step();
        logic [N-1:0] e_rdy;
        logic         e_wr;
        logic [7:0]   e_dat;
        drive();
        #1;
        e_rdy = '0;
        e_wr  = 1'b0;
        e_dat = 8'h00;
        if (m_owner >= 0 && !m_hdr) begin
            e_rdy[m_owner] = !tx_full;
            e_wr = req_valid[m_owner] && !tx_full;
            if (e_wr) e_dat = req_data[m_owner*DB +: DB];
        end
        if (m_owner >= 0 && m_hdr && !tx_full) begin
            e_wr  = 1'b1;
            e_dat = 8'hA0 | 8'(m_owner);
        end
        chk("req_ready",   32'(req_ready),   32'(e_rdy));
        chk("wr_uart",     32'(wr_uart),     32'(e_wr));
        chk("w_data",      32'(w_data),      32'(e_dat));
        chk("busy",        32'(busy),        32'(m_owner >= 0));
        chk("grant_id",    32'(grant_id),    32'(m_gid));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (wr_uart) begin
            wlog.push_back(w_data);
            wr_cyc.push_back(cyc);
        end
        if (timeout_err) to_cyc.push_back(cyc);
        for (int i = 0; i < N; i++) begin
            if (e_rdy[i] && req_valid[i]) begin
                void'(q_dat[i].pop_front());
                void'(q_lst[i].pop_front());
            end
        end
        m_terr = 1'b0;
        if (m_owner < 0) begin
            for (int j = 1; j <= N; j++) begin
                if (m_owner < 0 && req_valid[(m_ptr + j) % N]) begin
                    m_owner = (m_ptr + j) % N;
                    m_ptr   = m_owner;
                    m_gid   = m_owner;
                    m_hdr   = HDR_EN;
                    m_idle  = 0;
                end
            end
        end else if (m_hdr) begin
            if (!tx_full) m_hdr = 1'b0;
        end else if (e_wr && req_last[m_owner]) begin
            m_owner = -1;
            m_idle  = 0;
        end else if (!req_valid[m_owner]) begin
            m_idle++;
            if (m_idle == TO) begin
                m_terr  = 1'b1;
                m_owner = -1;
                m_idle  = 0;
            end
        end else begin
            m_idle = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        en        = '1;
        clear_queues();
        @(negedge clk);
        #1;
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_gid",   32'(grant_id),    32'd0);
        chk("rst_wr",    32'(wr_uart),     32'd0);
        chk("rst_ready", 32'(req_ready),   32'd0);
        chk("rst_terr",  32'(timeout_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        clear_logs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

`ifndef UART_TX_ARB_ID_HDR_EN
        // Single requester, three-byte message.
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
        run(6);
        chk("t1_count", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("t1_b0", 32'(wlog[0]), 32'h11);
            chk("t1_b1", 32'(wlog[1]), 32'h22);
            chk("t1_b2", 32'(wlog[2]), 32'h33);
            chk("t1_first_cyc", 32'(wr_cyc[0]), 32'd1);
            chk("t1_last_cyc",  32'(wr_cyc[2]), 32'd3);
        end

        // Two contenders from reset: req0 first, one idle gap, then req2.
        do_reset();
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        push(2, 8'h21, 0); push(2, 8'h22, 1);
        run(8);
        chk("t2_count", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            chk("t2_seq", {wlog[0], wlog[1], wlog[2], wlog[3]}, 32'h01022122);
            chk("t2_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
        end
        clear_logs();
        push(0, 8'h03, 1); push(2, 8'h23, 1);
        run(6);
        chk("t2_rr_first", (wlog.size() > 0) ? 32'(wlog[0]) : 32'hFFFF, 32'h03);

        // tx_full stall mid-message must not lose, duplicate or age the grant.
        do_reset();
        push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1);
        run(2);
        tx_full = 1'b1;
        run(5);
        tx_full = 1'b0;
        run(5);
        chk("t3_count", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3)
            chk("t3_seq", {8'h00, wlog[0], wlog[1], wlog[2]}, 32'h00313233);
        chk("t3_no_timeout", 32'(to_cyc.size()), 32'd0);

        // Granted requester goes silent; a waiting requester takes over after revocation.
        do_reset();
        push(0, 8'h40, 0);
        push(3, 8'h7E, 1);
        run(22);
        chk("t4_to_count", 32'(to_cyc.size()), 32'd1);
        if (to_cyc.size() == 1) chk("t4_to_cyc", 32'(to_cyc[0]), 32'd18);
        chk("t4_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) chk("t4_seq", {16'h0, wlog[0], wlog[1]}, 32'h407E);
`else
        // Header byte precedes the payload.
        push(3, 8'h55, 1);
        run(5);
        chk("hdr_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) chk("hdr_seq", {16'h0, wlog[0], wlog[1]}, 32'hA355);
`endif

        // Asynchronous reset in the middle of a message.
        do_reset();
        push(2, 8'h51, 0); push(2, 8'h52, 0); push(2, 8'h53, 1);
        run(3);
        drive();
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_wr",    32'(wr_uart),   32'd0);
        chk("arst_data",  32'(w_data),    32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_gid",   32'(grant_id),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        clear_queues();
        clear_logs();
        push(0, 8'h0A, 1); push(2, 8'h2A, 1);
        run(8);
        chk("arst_first", (wlog.size() > 0) ? 32'(wlog[0]) : 32'hFFFF, 32'h0A);

        // Randomized traffic with stalls, long silences and back-pressure.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q_dat[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
                if (stall[i] > 0) begin
                    stall[i]--;
                    en[i] = 1'b0;
                end else if ($urandom_range(0, 299) == 0) begin
                    stall[i] = TO + 4;
                    en[i] = 1'b0;
                end else begin
                    en[i] = ($urandom_range(0, 9) != 0);
                end
            end
            tx_full = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
